fc_l2_port_arbiter: RTL

Round-robin arbiter sharing one L2 TCDM-protocol master port among NB_REQ requesters, e.g. the fabric-controller data port and the FC HWPE master ports. It sits between the requesters and the SoC interconnect. It grants one request per cycle and records the winner's index in an in-order outstanding FIFO. It routes each returning response (r_valid/r_rdata/r_opc) back to the requester that issued it.

---
 rtl/fc_l2_port_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fc_l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 TCDM master port among NB_REQ requesters.
// An in-order FIFO of granted requester indices routes each response back to its issuer.
module fc_l2_port_arbiter #(
  parameter int NB_REQ          = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NB_REQ-1:0]                  req_i,
  input  logic [NB_REQ*ADDR_WIDTH-1:0]       add_i,
  input  logic [NB_REQ-1:0]                  wen_i,
  input  logic [NB_REQ*DATA_WIDTH-1:0]       wdata_i,
  input  logic [NB_REQ*(DATA_WIDTH/8)-1:0]   be_i,
  output logic [NB_REQ-1:0]                  gnt_o,
  output logic [NB_REQ-1:0]                  r_valid_o,
  output logic [DATA_WIDTH-1:0]              r_rdata_o,
  output logic                               r_opc_o,
  output logic                               m_req_o,
  output logic [ADDR_WIDTH-1:0]              m_add_o,
  output logic                               m_wen_o,
  output logic [DATA_WIDTH-1:0]              m_wdata_o,
  output logic [DATA_WIDTH/8-1:0]            m_be_o,
  input  logic                               m_gnt_i,
  input  logic                               m_r_valid_i,
  input  logic [DATA_WIDTH-1:0]              m_r_rdata_i,
  input  logic                               m_r_opc_i,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               err_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W    = $clog2(NB_REQ);
  localparam int PTR_W    = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W    = PTR_W + 1;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Per-requester payload views of the flattened input buses
  logic [ADDR_WIDTH-1:0] add_arr   [NB_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NB_REQ];
  logic [BE_WIDTH-1:0]   be_arr    [NB_REQ];

  for (genvar g = 0; g < NB_REQ; g++) begin : g_unpack
    assign add_arr[g]   = add_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign be_arr[g]    = be_i[g*BE_WIDTH +: BE_WIDTH];
  end

  idx_t prio_q;
  idx_t winner;
  idx_t next_prio;
  logic any_req;
  logic full;
  logic push;
  logic pop;

  ptr_t wr_ptr_q;
  ptr_t rd_ptr_q;
  cnt_t count_q;
  logic err_q;
  idx_t fifo_q [MAX_OUTSTANDING];

  // Priority scan starting at prio_q, wrapping modulo NB_REQ; first requester found wins.
  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    int cand;
    cand    = 0;
    winner  = prio_q;
    any_req = 1'b0;
    for (int k = 0; k < NB_REQ; k++) begin
      cand = (int'(prio_q) + k) % NB_REQ;
      if (!any_req && req_i[idx_t'(cand)]) begin
        any_req = 1'b1;
        winner  = idx_t'(cand);
      end
    end
  end

  // full comes from the registered count only, so a same-cycle pop never unblocks a grant.
  assign full      = (count_q == cnt_t'(MAX_OUTSTANDING));
  assign m_req_o   = any_req & ~full;
  assign push      = m_req_o & m_gnt_i;
  assign pop       = m_r_valid_i & (count_q != '0);
  assign next_prio = (winner == idx_t'(NB_REQ - 1)) ? '0 : winner + idx_t'(1);

  assign m_add_o   = add_arr[winner];
  assign m_wen_o   = wen_i[winner];
  assign m_wdata_o = wdata_arr[winner];
  assign m_be_o    = be_arr[winner];

  always_comb begin
    gnt_o = '0;
    if (push) gnt_o[winner] = 1'b1;
  end

  always_comb begin
    r_valid_o = '0;
    if (pop) r_valid_o[fifo_q[rd_ptr_q]] = 1'b1;
  end

  assign r_rdata_o     = m_r_rdata_i;
  assign r_opc_o       = m_r_opc_i;
  assign outstanding_o = count_q;
  assign err_o         = err_q;

  // NOTE: state registers use non-blocking assignments; reset is synchronous, so it is
  // tested inside the clocked block rather than appearing in the sensitivity list.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + ptr_t'(1);
        prio_q   <= next_prio;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + cnt_t'(1);
        2'b01:   count_q <= count_q - cnt_t'(1);
        default: count_q <= count_q;
      endcase
      if (m_r_valid_i && (count_q == '0)) err_q <= 1'b1;
    end
  end

  // NOTE: the index storage is not reset; count_q alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= winner;
  end

endmodule
